// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [3:0]  HALT_OPCODE = 4'hE;
  localparam int unsigned PC_STEP     = 2;
  localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: control inputs, instruction memory port and IF/ID outputs.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16
);
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc_plus2;
  logic               fault;
  logic               halted;
  logic [15:0]        fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_data,
    output imem_addr, instr, instr_pc, instr_valid, pc_plus2, fault, halted, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_data,
    input  imem_addr, instr, instr_pc, instr_valid, pc_plus2, fault, halted, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer_pc_next_select.sv
// Combinational next-PC selection with redirect/stall priority and range/alignment checks.
module pc_next_select
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_WORDS = 30
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc_next,
  output logic              fetch,
  output logic              redirect_ok,
  output logic              fault_set
);
  localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W+1)'(2 * MEM_WORDS);

  logic tgt_ok;
  logic pc_ok;

  assign tgt_ok = !redirect_target[0] && ({1'b0, redirect_target} < PC_LIMIT);
  assign pc_ok  = !pc[0] && ({1'b0, pc} < PC_LIMIT);

  always_comb begin
    pc_next     = pc;
    fetch       = 1'b0;
    redirect_ok = 1'b0;
    fault_set   = 1'b0;
    if (redirect_valid) begin
      if (tgt_ok) begin
        pc_next     = redirect_target;
        redirect_ok = 1'b1;
      end else begin
        fault_set = 1'b1;
      end
    end else if (!stall) begin
      if (!pc_ok) begin
        fault_set = 1'b1;
      end else begin
        fetch   = 1'b1;
        pc_next = pc + ADDR_W'(PC_STEP);
      end
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, IF/ID register, sticky fault and fetch counter.
// Optional halt-opcode detection enabled by defining FETCH_HALT_DETECT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned MEM_WORDS = 30,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);
  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;
  logic               halted_q, halted_d;
  logic [15:0]        count_q, count_d;

  logic [ADDR_W-1:0]  pc_next;
  logic               fetch, redirect_ok, fault_set;

  pc_next_select #(
    .ADDR_W    (ADDR_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_pc_next_select (
    .pc              (pc_q),
    .stall           (bus.stall),
    .redirect_valid  (bus.redirect_valid),
    .redirect_target (bus.redirect_target),
    .pc_next         (pc_next),
    .fetch           (fetch),
    .redirect_ok     (redirect_ok),
    .fault_set       (fault_set)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= ADDR_W'(RESET_PC);
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    halted_d   = halted_q;
    count_d    = count_q;
    case (state_q)
      RUN: begin
        if (redirect_ok) begin
          pc_d    = pc_next;
          valid_d = 1'b0;
        end else if (fault_set) begin
          state_d = FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (fetch) begin
          instr_d    = bus.imem_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_next;
          if (count_q != COUNT_MAX) count_d = count_q + 16'd1;
`ifdef FETCH_HALT_DETECT_EN
          // Halt word is still delivered and counted; the state change stops further fetches.
          if (bus.imem_data[INSTR_W-1 -: 4] == HALT_OPCODE) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
`endif
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc_plus2    = instr_pc_q + ADDR_W'(PC_STEP);
  assign bus.fault       = fault_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational instruction memory model.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mem [0:31];
  logic [15:0] exp25;

  fetch_sequencer_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  fetch_sequencer #(
    .ADDR_W    (16),
    .INSTR_W   (16),
    .MEM_WORDS (30),
    .RESET_PC  (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.imem_data = mem[bus.imem_addr[5:1]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0120 + 16'(i);
    mem[25] = 16'hEFFF;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    @(negedge clk);
    @(negedge clk);

    chk("rst_valid",  bus.instr_valid, 0);
    chk("rst_instr",  bus.instr, 0);
    chk("rst_ipc",    bus.instr_pc, 0);
    chk("rst_fault",  bus.fault, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_count",  bus.fetch_count, 0);
    chk("rst_addr",   bus.imem_addr, 0);

    // Two back-to-back fetches
    reset = 1'b0;
    step();
    chk("f1_instr", bus.instr, 16'h0120);
    chk("f1_ipc",   bus.instr_pc, 0);
    chk("f1_valid", bus.instr_valid, 1);
    chk("f1_link",  bus.pc_plus2, 2);
    step();
    chk("f2_instr", bus.instr, 16'h0121);
    chk("f2_ipc",   bus.instr_pc, 2);
    chk("f2_count", bus.fetch_count, 2);

    // Stall held for three cycles after the first fetch
    do_reset();
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_instr", bus.instr, 16'h0120);
      chk("st_addr",  bus.imem_addr, 2);
      chk("st_count", bus.fetch_count, 1);
      chk("st_valid", bus.instr_valid, 1);
    end
    bus.stall = 1'b0;
    step();
    chk("st_resume", bus.instr, 16'h0121);
    chk("st_rcount", bus.fetch_count, 2);

    // Redirect overrides simultaneous stall
    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 16'h0018;
    step();
    chk("rd_bubble", bus.instr_valid, 0);
    chk("rd_addr",   bus.imem_addr, 16'h0018);
    chk("rd_count",  bus.fetch_count, 2);
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    chk("rd_ipc",   bus.instr_pc, 16'h0018);
    chk("rd_instr", bus.instr, 16'h012C);
    chk("rd_valid", bus.instr_valid, 1);

    // Redirect to the current pc re-fetches after one bubble
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 16'h001A;
    step();
    chk("self_bubble", bus.instr_valid, 0);
    chk("self_addr",   bus.imem_addr, 16'h001A);
    bus.redirect_valid = 1'b0;
    step();
    chk("self_ipc",   bus.instr_pc, 16'h001A);
    chk("self_instr", bus.instr, 16'h012D);
    chk("self_count", bus.fetch_count, 4);

    // Misaligned redirect faults; fault is sticky
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 16'h0005;
    step();
    chk("mis_fault", bus.fault, 1);
    chk("mis_valid", bus.instr_valid, 0);
    chk("mis_addr",  bus.imem_addr, 16'h001C);
    bus.redirect_target = 16'h0010;
    bus.stall = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    step();
    chk("fs_fault", bus.fault, 1);
    chk("fs_addr",  bus.imem_addr, 16'h001C);
    chk("fs_valid", bus.instr_valid, 0);
    chk("fs_instr", bus.instr, 16'h012D);
    chk("fs_count", bus.fetch_count, 4);

    // Out-of-range redirect also faults
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 16'h003C;
    step();
    chk("oor_fault", bus.fault, 1);
    chk("oor_addr",  bus.imem_addr, 0);
    bus.redirect_valid = 1'b0;

    // Asynchronous reset mid-cycle clears fault
    #1 reset = 1'b1;
    #1;
    chk("ar_fault", bus.fault, 0);
    chk("ar_addr",  bus.imem_addr, 0);
    chk("ar_count", bus.fetch_count, 0);
    @(negedge clk);
    reset = 1'b0;

`ifdef FETCH_HALT_DETECT_EN
    // Halt opcode at word 25
    repeat (25) step();
    step();
    chk("h_instr",  bus.instr, 16'hEFFF);
    chk("h_ipc",    bus.instr_pc, 16'h0032);
    chk("h_valid",  bus.instr_valid, 1);
    chk("h_halted", bus.halted, 1);
    chk("h_count",  bus.fetch_count, 26);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 16'h0000;
    step();
    bus.redirect_valid = 1'b0;
    chk("h_drop",   bus.instr_valid, 0);
    chk("h_addr",   bus.imem_addr, 16'h0034);
    step();
    chk("h_frozen", bus.imem_addr, 16'h0034);
    chk("h_count2", bus.fetch_count, 26);
    chk("h_still",  bus.halted, 1);
    #1 reset = 1'b1;
    #1;
    chk("hr_halted", bus.halted, 0);
    chk("hr_addr",   bus.imem_addr, 0);
    chk("hr_count",  bus.fetch_count, 0);
    @(negedge clk);
    reset = 1'b0;
    mem[25] = 16'h0139;
`endif
    exp25 = mem[25];

    // Sequential run off the end of memory
    repeat (25) step();
    step();
    chk("w25_instr",  bus.instr, exp25);
    chk("w25_halted", bus.halted, 0);
    chk("w25_valid",  bus.instr_valid, 1);
    repeat (3) step();
    step();
    chk("end_ipc",   bus.instr_pc, 16'h003A);
    chk("end_instr", bus.instr, 16'h013D);
    chk("end_valid", bus.instr_valid, 1);
    chk("end_fault", bus.fault, 0);
    chk("end_count", bus.fetch_count, 30);
    chk("end_link",  bus.pc_plus2, 16'h003C);
    step();
    chk("off_fault", bus.fault, 1);
    chk("off_valid", bus.instr_valid, 0);
    chk("off_ipc",   bus.instr_pc, 16'h003A);
    chk("off_count", bus.fetch_count, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and drives the instruction memory read address.
- Registers each fetched 16-bit instruction into an IF/ID holding register with a valid flag.
- Handles pipeline stall, branch/jump redirect with squash, range/alignment faults and fetch counting.
- Sits between the instruction memory (combinational read, byte address, word index = address/2) and decode.

Parameters:
- ADDR_W, 16, PC / memory address width in bits
- INSTR_W, 16, instruction width
- MEM_WORDS, 30, number of instruction words; valid byte addresses are 0 .. 2*MEM_WORDS-2, even only
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold the fetch stage; IF/ID contents and PC frozen
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_target  input  ADDR_W  byte address of the new PC
- imem_addr  output  ADDR_W  read address to instruction memory; equals pc
- imem_data  input  INSTR_W  instruction word returned combinationally for imem_addr
- instr  output  INSTR_W  IF/ID instruction register
- instr_pc  output  ADDR_W  byte address instr was fetched from
- instr_valid  output  1  instr holds a live instruction
- pc_plus2  output  ADDR_W  instr_pc+2 (combinational, link value for decode)
- fault  output  1  sticky fetch fault
- halted  output  1  halt detected (optional feature)
- fetch_count  output  16  number of instructions delivered, saturating

Behaviour:
- Reset (asynchronous, any time, including mid-redirect or mid-stall) sets:
  - pc=RESET_PC, state=RUN
  - instr=0, instr_pc=0, instr_valid=0
  - fault=0, halted=0, fetch_count=0
- States: RUN, FAULT, HALT.
- imem_addr = pc at all times. Fetch latency is 1 cycle: the word at pc appears on instr after the next rising edge.
- RUN, per edge, in priority order:
  1. redirect_valid=1, target legal (even, < 2*MEM_WORDS): pc<=target; instr_valid<=0, a one-cycle bubble. Redirect overrides stall in the same cycle.
  2. redirect_valid=1, target odd or out of range: state<=FAULT, fault<=1, instr_valid<=0, pc unchanged.
  3. stall=1: all registers hold.
  4. pc out of range (fell off end by sequential increment): state<=FAULT, fault<=1, instr_valid<=0.
  5. otherwise:
     - instr<=imem_data, instr_pc<=pc, instr_valid<=1
     - pc<=pc+2, computed mod 2^ADDR_W
     - fetch_count<=fetch_count+1, saturating at 16'hFFFF
- FAULT: sticky until reset.
  - instr_valid=0; pc, instr, instr_pc frozen.
  - stall and redirect ignored.
- HALT: only reachable with the optional feature.
  - pc frozen; instr_valid drops to 0 on the edge after the halt instruction was delivered.
  - stall and redirect ignored; sticky until reset.
- Boundaries:
  - Last legal word (2*MEM_WORDS-2) is fetched normally; the next cycle faults.
  - Redirect to the current pc is legal: re-fetch after one bubble.
  - Stall held across many cycles produces no extra fetches and no count change.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - A fetched word with instr[15:12]==4'hE (HALT opcode) is delivered with instr_valid=1 for one cycle.
  - State then moves to HALT, halted=1.
  - fetch_count includes the halt instruction.
- Undefined:
  - halted tied to 0.
  - Opcode 4'hE is fetched like any other instruction; no HALT state is synthesised.

Decomposition:
- Package fetch_pkg:
  - state enum {RUN, FAULT, HALT}
  - HALT_OPCODE=4'hE
  - PC_STEP=2
  - COUNT_MAX=16'hFFFF
- Sub-module pc_next_select: combinational next-PC and fault-condition logic (redirect / stall / increment / range and alignment checks).
- The top level holds the registers and state.

Test Plan:
- Bench memory word0=16'h0120, word1=16'h0121, no stall; release reset -> cycle1 instr=16'h0120 instr_pc=0; cycle2 instr=16'h0121 instr_pc=2; fetch_count=2.
- stall=1 for 3 cycles after first fetch -> instr=16'h0120, pc=2, count=1 held constant; resumes with 16'h0121.
- redirect_valid=1, target=16'h0018, with stall=1 simultaneously -> next edge instr_valid=0; following edge instr_pc=16'h0018 with word 12.
- redirect_target=16'h0005 -> fault=1 next edge, instr_valid=0; subsequent redirects/stall ignored; reset clears fault=0, pc=0.
- Run sequentially to pc=16'h003A (MEM_WORDS=30) -> word 29 delivered at instr_pc=16'h003A, then fault=1 one cycle later.
- With FETCH_HALT_DETECT_EN, word 25=16'hEFFF -> delivered with instr_valid=1, halted=1, pc frozen, instr_valid=0 thereafter; reset asserted mid-HALT clears everything.
